// File: rtl/scr1_tb_instr_match_mon_pkg.sv
// scr1_tb_instr_mon_pkg: snapshot entry type, widths and common opcode mask/value pairs
// shared by the instruction match monitor, its FIFO and its interface.
package scr1_tb_instr_mon_pkg;

    localparam int SCR1_XLEN                  = 32;
    localparam int SCR1_CSR_COUNTERS_WIDTH    = 64;
    localparam int SCR1_TB_INSTR_MON_CH_W_MAX = 4;

    localparam logic [31:0] SCR1_TB_INSTR_MASK_XOR   = 32'hFE00707F;
    localparam logic [31:0] SCR1_TB_INSTR_VALUE_XOR  = 32'h00004033;
    localparam logic [31:0] SCR1_TB_INSTR_MASK_ADD   = 32'hFE00707F;
    localparam logic [31:0] SCR1_TB_INSTR_VALUE_ADD  = 32'h00000033;
    localparam logic [31:0] SCR1_TB_INSTR_MASK_SUB   = 32'hFE00707F;
    localparam logic [31:0] SCR1_TB_INSTR_VALUE_SUB  = 32'h40000033;
    localparam logic [31:0] SCR1_TB_INSTR_MASK_OPC   = 32'h0000007F;
    localparam logic [31:0] SCR1_TB_INSTR_VALUE_OP   = 32'h00000033;
    localparam logic [31:0] SCR1_TB_INSTR_VALUE_CSR  = 32'h00000073;

    typedef struct packed {
        logic [SCR1_TB_INSTR_MON_CH_W_MAX-1:0] ch;
        logic [SCR1_XLEN-1:0]                  pc;
        logic [SCR1_XLEN-1:0]                  mstatus;
        logic [SCR1_CSR_COUNTERS_WIDTH-1:0]    mcycle;
    } type_scr1_tb_instr_snap_s;

    function automatic logic scr1_tb_instr_hit(
        input logic [31:0] instr,
        input logic [31:0] mask,
        input logic [31:0] value
    );
        return (instr & mask) == value;
    endfunction

endpackage

// File: rtl/scr1_tb_instr_match_mon_if.sv
// scr1_tb_instr_match_mon_if: IFU->IDU instruction handshake plus the snapshot drain port.
// master = bench / pipeline side, slave = monitor.
interface scr1_tb_instr_match_mon_if;
    import scr1_tb_instr_mon_pkg::*;

    logic                               instr_vd;
    logic                               instr_rdy;
    logic [31:0]                        instr;
    logic [SCR1_XLEN-1:0]               pc;
    logic [SCR1_XLEN-1:0]               csr_mstatus;
    logic [SCR1_CSR_COUNTERS_WIDTH-1:0] csr_mcycle;
    logic                               snap_vd;
    logic                               snap_rdy;
    type_scr1_tb_instr_snap_s           snap;

    modport master (
        output instr_vd, instr_rdy, instr, pc, csr_mstatus, csr_mcycle, snap_rdy,
        input  snap_vd, snap
    );

    modport slave (
        input  instr_vd, instr_rdy, instr, pc, csr_mstatus, csr_mcycle, snap_rdy,
        output snap_vd, snap
    );

endinterface

// File: rtl/scr1_tb_instr_match_mon_snap_fifo.sv
// scr1_tb_instr_snap_fifo: bounded snapshot FIFO with registered head, no fall-through,
// and push accepted on full only when a pop happens in the same cycle.
module scr1_tb_instr_snap_fifo
    import scr1_tb_instr_mon_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  type_scr1_tb_instr_snap_s wdata_i,
    input  logic                     pop_i,
    output logic                     vld_o,
    output type_scr1_tb_instr_snap_s rdata_o,
    output logic                     drop_o
);
    localparam int AW = $clog2(DEPTH);

    type_scr1_tb_instr_snap_s mem_q [DEPTH];
    logic [AW-1:0]            wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]            rd_ptr_q, rd_ptr_d;
    logic [AW:0]              cnt_q, cnt_d;
    logic                     empty, full, do_push, do_pop;

    assign empty   = cnt_q == '0;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign do_pop  = pop_i & ~empty;
    assign do_push = push_i & (~full | do_pop);
    assign drop_o  = push_i & ~do_push;
    assign vld_o   = ~empty;
    // Head is forced to zero while empty so stale slots never leak out.
    assign rdata_o = empty ? type_scr1_tb_instr_snap_s'('0) : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = do_pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/scr1_tb_instr_match_mon.sv
// scr1_tb_instr_match_mon: multi-channel mask/value instruction matcher with saturating hit counters
// and a snapshot FIFO. Define SCR1_TB_INSTR_MON_DISPLAY_EN to print every push and drop.
module scr1_tb_instr_match_mon
    import scr1_tb_instr_mon_pkg::*;
#(
    parameter int CH_NUM = 4,
    parameter int CH_W   = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    scr1_tb_instr_match_mon_if.slave        mon,
    input  logic [CH_NUM-1:0]               ch_en,
    input  logic [CH_NUM-1:0][31:0]         ch_mask,
    input  logic [CH_NUM-1:0][31:0]         ch_value,
    output logic [CH_NUM-1:0][CNT_W-1:0]    hit_cnt,
    output logic [CNT_W-1:0]                drop_cnt,
    output logic                            ovf
);
    logic                             accept, push, drop, snap_vd;
    logic [CH_NUM-1:0]                hit;
    logic [CH_W-1:0]                  hit_ch;
    type_scr1_tb_instr_snap_s         push_entry, snap;
    logic [CH_NUM-1:0][CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]                 drop_cnt_q, drop_cnt_d;
    logic                             ovf_q, ovf_d;

    assign accept = mon.instr_vd & mon.instr_rdy;

    // Descending scan leaves the lowest-index hitting channel in hit_ch.
    always_comb begin
        hit    = '0;
        hit_ch = '0;
        for (int i = CH_NUM - 1; i >= 0; i--) begin
            hit[i] = ch_en[i] & scr1_tb_instr_hit(mon.instr, ch_mask[i], ch_value[i]);
            if (hit[i]) hit_ch = CH_W'(i);
        end
    end

    assign push       = accept & (|hit);
    assign push_entry = '{
        ch:      SCR1_TB_INSTR_MON_CH_W_MAX'(hit_ch),
        pc:      mon.pc,
        mstatus: mon.csr_mstatus,
        mcycle:  mon.csr_mcycle
    };

    scr1_tb_instr_snap_fifo #(.DEPTH(DEPTH)) i_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i (push_entry),
        .pop_i   (mon.snap_rdy),
        .vld_o   (snap_vd),
        .rdata_o (snap),
        .drop_o  (drop)
    );

    assign mon.snap_vd = snap_vd;
    assign mon.snap    = snap;

    always_comb begin
        hit_cnt_d = hit_cnt_q;
        for (int i = 0; i < CH_NUM; i++) begin
            if (accept & hit[i] & ~&hit_cnt_q[i]) hit_cnt_d[i] = hit_cnt_q[i] + CNT_W'(1);
        end
        drop_cnt_d = (drop & ~&drop_cnt_q) ? drop_cnt_q + CNT_W'(1) : drop_cnt_q;
        ovf_d      = ovf_q | drop;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            hit_cnt_q  <= hit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign drop_cnt = drop_cnt_q;
    assign ovf      = ovf_q;

`ifdef SCR1_TB_INSTR_MON_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (rst_n & push & ~drop)
            $display("instr_mon: push ch=%0d pc=%h mstatus=%h mcycle=%h",
                     hit_ch, mon.pc, mon.csr_mstatus, mon.csr_mcycle);
        if (rst_n & drop)
            $display("instr_mon: snapshot dropped, drop_cnt=%0d", {1'b0, drop_cnt_q} + 1'b1);
    end
`else
    // Silent build: the same logic with no console side effects.
`endif

endmodule

// File: tb/tb_scr1_tb_instr_match_mon.sv
// tb_scr1_tb_instr_match_mon: directed plan checks plus a randomized run scored against
// a queue-based reference model; a negedge monitor pops and compares snapshots.
module tb_scr1_tb_instr_match_mon;
    import scr1_tb_instr_mon_pkg::*;

    localparam int CH_NUM  = 4;
    localparam int DEPTH   = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                         clk = 1'b0;
    logic                         rst_n;
    logic [CH_NUM-1:0]            ch_en;
    logic [CH_NUM-1:0][31:0]      ch_mask;
    logic [CH_NUM-1:0][31:0]      ch_value;
    logic [CH_NUM-1:0][CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0]             drop_cnt;
    logic                         ovf;

    scr1_tb_instr_match_mon_if bus ();

    scr1_tb_instr_match_mon #(.CH_NUM(CH_NUM), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .mon      (bus),
        .ch_en    (ch_en),
        .ch_mask  (ch_mask),
        .ch_value (ch_value),
        .hit_cnt  (hit_cnt),
        .drop_cnt (drop_cnt),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    bit mon_on = 1'b0;

    type_scr1_tb_instr_snap_s exp_q[$];
    int occ = 0;
    int m_hit[CH_NUM];
    int m_drop = 0;
    bit m_ovf = 1'b0;

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic type_scr1_tb_instr_snap_s mk(input int ch, input logic [31:0] p,
                                                    input logic [31:0] ms, input logic [63:0] mc);
        type_scr1_tb_instr_snap_s s;
        s.ch      = SCR1_TB_INSTR_MON_CH_W_MAX'(ch);
        s.pc      = p;
        s.mstatus = ms;
        s.mcycle  = mc;
        return s;
    endfunction

    // Reference model: behaviour stated directly as a bounded queue with saturating tallies.
    always @(posedge clk) begin : model
        bit pop_now;
        int first;
        if (!rst_n) begin
            exp_q.delete();
            occ = 0;
            foreach (m_hit[i]) m_hit[i] = 0;
            m_drop = 0;
            m_ovf  = 1'b0;
        end else begin
            pop_now = (occ > 0) && bus.snap_rdy;
            first   = -1;
            if (bus.instr_vd && bus.instr_rdy) begin
                for (int i = 0; i < CH_NUM; i++) begin
                    if (ch_en[i] && ((bus.instr & ch_mask[i]) == ch_value[i])) begin
                        if (m_hit[i] < CNT_MAX) m_hit[i]++;
                        if (first < 0) first = i;
                    end
                end
            end
            if (first >= 0) begin
                if (occ < DEPTH || pop_now) begin
                    exp_q.push_back(mk(first, bus.pc, bus.csr_mstatus, bus.csr_mcycle));
                    occ++;
                end else begin
                    if (m_drop < CNT_MAX) m_drop++;
                    m_ovf = 1'b1;
                end
            end
            if (pop_now) occ--;
        end
    end

    always @(negedge clk) begin
        if (mon_on) begin
            check("mon_snap_vd", bus.snap_vd, occ != 0);
            if (bus.snap_vd && bus.snap_rdy) begin
                if (exp_q.size() == 0) check("mon_unexpected_pop", 1'b1, 1'b0);
                else check("mon_snap", bus.snap, exp_q.pop_front());
            end
            for (int i = 0; i < CH_NUM; i++) check("mon_hit_cnt", hit_cnt[i], m_hit[i]);
            check("mon_drop_cnt", drop_cnt, m_drop);
            check("mon_ovf", ovf, m_ovf);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic vd, input logic rdy, input logic [31:0] ins,
                          input logic [31:0] p, input logic [31:0] ms, input logic [63:0] mc);
        bus.instr_vd    = vd;
        bus.instr_rdy   = rdy;
        bus.instr       = ins;
        bus.pc          = p;
        bus.csr_mstatus = ms;
        bus.csr_mcycle  = mc;
    endtask

    task automatic idle();
        bus.instr_vd  = 1'b0;
        bus.instr_rdy = 1'b0;
    endtask

    task automatic pulse_rst();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
    endtask

    function automatic logic [31:0] pick_instr();
        case ($urandom_range(0, 4))
            0:       return 32'h00C5C533;
            1:       return 32'h00B50533;
            2:       return 32'h40B50533;
            3:       return 32'h30200073;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        bus.snap_rdy = 1'b0;
        ch_en    = '0;
        ch_mask  = '0;
        ch_value = '0;
        cyc();
        cyc();
        check("rst_snap_vd", bus.snap_vd, 1'b0);
        check("rst_snap", bus.snap, '0);
        check("rst_hit_cnt", hit_cnt, '0);
        check("rst_drop_cnt", drop_cnt, '0);
        check("rst_ovf", ovf, 1'b0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // Single XOR hit
        ch_mask[0]  = 32'hFE00707F;
        ch_value[0] = 32'h00004033;
        ch_en       = 4'b0001;
        set_in(1, 1, 32'h00C5C533, 32'h200, 32'h1800, 64'h55);
        cyc();
        idle();
        check("t1_snap_vd", bus.snap_vd, 1'b1);
        check("t1_snap", bus.snap, mk(0, 32'h200, 32'h1800, 64'h55));
        check("t1_hit_cnt0", hit_cnt[0], 1);
        bus.snap_rdy = 1'b1;
        cyc();
        bus.snap_rdy = 1'b0;
        check("t1_empty", bus.snap_vd, 1'b0);

        // Stalled handshake counts once
        pulse_rst();
        set_in(1, 0, 32'h00C5C533, 32'h204, 32'h1800, 64'h60);
        repeat (3) cyc();
        check("t2_no_accept", hit_cnt[0], 0);
        bus.instr_rdy = 1'b1;
        cyc();
        idle();
        check("t2_hit_cnt0", hit_cnt[0], 1);
        check("t2_snap_vd", bus.snap_vd, 1'b1);
        bus.snap_rdy = 1'b1;
        cyc();
        bus.snap_rdy = 1'b0;
        check("t2_one_entry", bus.snap_vd, 1'b0);

        // Two channels hit, lowest index pushes
        pulse_rst();
        ch_mask[1]  = 32'h0000007F;
        ch_value[1] = 32'h00000033;
        ch_en       = 4'b0011;
        set_in(1, 1, 32'h00C5C533, 32'h208, 32'h1880, 64'h70);
        cyc();
        idle();
        check("t3_hit_cnt0", hit_cnt[0], 1);
        check("t3_hit_cnt1", hit_cnt[1], 1);
        check("t3_snap_ch", bus.snap.ch, 0);
        bus.snap_rdy = 1'b1;
        cyc();
        bus.snap_rdy = 1'b0;
        check("t3_one_entry", bus.snap_vd, 1'b0);

        // Overflow: 10 hits into 8 slots
        pulse_rst();
        for (int i = 0; i < 10; i++) begin
            set_in(1, 1, 32'h00C5C533, 32'h100 + 4 * i, 32'h1800, 64'(i));
            cyc();
        end
        idle();
        check("t4_drop_cnt", drop_cnt, 2);
        check("t4_ovf", ovf, 1'b1);
        check("t4_head_pc", bus.snap.pc, 32'h100);

        // Full FIFO: pop and push in the same cycle
        bus.snap_rdy = 1'b1;
        set_in(1, 1, 32'h00C5C533, 32'h300, 32'h1800, 64'h99);
        cyc();
        bus.snap_rdy = 1'b0;
        idle();
        check("t5_drop_unchanged", drop_cnt, 2);
        set_in(1, 1, 32'h00C5C533, 32'h400, 32'h1800, 64'h9A);
        cyc();
        idle();
        check("t5_still_full", drop_cnt, 3);
        for (int k = 0; k < 5; k++) begin
            check("t5_drain_pc", bus.snap.pc, 32'h104 + 4 * k);
            bus.snap_rdy = 1'b1;
            cyc();
        end
        bus.snap_rdy = 1'b0;
        check("t6_pre_ovf", ovf, 1'b1);
        check("t6_pre_vd", bus.snap_vd, 1'b1);

        // Reset with entries queued; accept during reset ignored
        rst_n = 1'b0;
        set_in(1, 1, 32'h00C5C533, 32'h500, 32'h1800, 64'hAA);
        cyc();
        rst_n = 1'b1;
        idle();
        check("t6_snap_vd", bus.snap_vd, 1'b0);
        check("t6_ovf", ovf, 1'b0);
        check("t6_drop_cnt", drop_cnt, 0);
        check("t6_hit_cnt", hit_cnt, '0);

        // Randomized traffic against the reference model
        ch_mask[3]  = 32'hFE00707F;
        ch_value[3] = 32'h00000033;
        for (int c = 0; c < 600; c++) begin
            if (c % 50 == 0) begin
                ch_en       = 4'($urandom);
                ch_mask[2]  = $urandom;
                ch_value[2] = $urandom & ch_mask[2] & 32'h0000FFFF;
                ch_mask[2]  = ch_mask[2] & 32'h0000FFFF;
            end
            set_in(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0), pick_instr(),
                   $urandom, $urandom, {$urandom, $urandom});
            bus.snap_rdy = (c < 300) ? ($urandom_range(0, 9) < 2) : ($urandom_range(0, 9) < 7);
            if (c == 450) rst_n = 1'b0;
            cyc();
            rst_n = 1'b1;
        end
        idle();
        bus.snap_rdy = 1'b1;
        for (int c = 0; c < 4 * DEPTH && bus.snap_vd; c++) cyc();
        cyc();
        check("final_drained", bus.snap_vd, 1'b0);
        check("final_queue_empty", exp_q.size(), 0);
        mon_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/scr1_tb_instr_match_mon.md
# scr1_tb_instr_match_mon

Parametrised testbench monitor on the IFU→IDU instruction handshake. It compares every accepted instruction against `CH_NUM` programmable mask/value channels. On a hit it counts per channel and pushes a snapshot {channel, pc, mstatus, mcycle} into a bounded FIFO that the bench drains over a valid/ready port. It sits beside `i_pipe_ifu` in the AHB/AXI top testbenches and generalises single-opcode CSR logging to many channels, with qualification, counting, buffering and back-pressure.

## Interface
- `CH_NUM`, 4: number of match channels (1..16).
- `CH_W`, `$clog2(CH_NUM)` (min 1): channel-index width.
- `DEPTH`, 8: snapshot FIFO depth (power of two, ≥2).
- `CNT_W`, 32: per-channel hit counter and drop counter width.
- `clk` input 1: monitor clock (same as core clock).
- `rst_n` input 1: one clock; reset is synchronous and active-low.
- `instr_vd` input 1: IFU→IDU instruction valid.
- `instr_rdy` input 1: IDU→IFU ready. Accept = `instr_vd & instr_rdy`.
- `instr` input 32: instruction word.
- `pc` input `SCR1_XLEN`: PC of `instr`.
- `csr_mstatus` input `SCR1_XLEN`: mstatus sample.
- `csr_mcycle` input `SCR1_CSR_COUNTERS_WIDTH`: mcycle sample.
- `ch_en` input `CH_NUM`: per-channel enable.
- `ch_mask` input `CH_NUM`×32: per-channel compare mask.
- `ch_value` input `CH_NUM`×32: per-channel compare value.
- `snap_vd` output 1: FIFO head valid.
- `snap_rdy` input 1: bench consumes head.
- `snap` output entry type: head entry {ch, pc, mstatus, mcycle}.
- `hit_cnt` output `CH_NUM`×`CNT_W`: per-channel hit counts.
- `drop_cnt` output `CNT_W`: snapshots lost to a full FIFO.
- `ovf` output 1: sticky, set on the first drop.

## Operation
- Channel i hits when `ch_en[i] & ((instr & ch_mask[i]) == ch_value[i])`. Hits are evaluated only on accept.
- Several channels hitting: every hit counter increments. Only the lowest-index hitting channel pushes a snapshot (one push per instruction).
- Counters saturate at all-ones and never wrap. `drop_cnt` saturates the same way.
- Push condition: accept & any hit.
  - The push is accepted when the FIFO is not full, or when it is full and a pop (`snap_vd & snap_rdy`) occurs in the same cycle.
  - Otherwise the snapshot is dropped, `drop_cnt` increments and `ovf` sets.
- Pop: `snap_vd & snap_rdy`. The FIFO is ordered by accept time.
- Push and pop on an empty FIFO: the entry is written; `snap_vd` rises next cycle. There is no fall-through.
- `ch_mask`/`ch_value`/`ch_en` changes take effect in the same cycle they are applied.
- Reset mid-operation: all FIFO contents, counters and `ovf` are cleared. An accept in the reset cycle is ignored.

## Timing
- Reset values: `snap_vd`=0, `snap`=0, `hit_cnt`=0, `drop_cnt`=0, `ovf`=0.
- `pc`, `csr_mstatus` and `csr_mcycle` are sampled at the accepting edge.
- Latency: entry on `snap` with `snap_vd`=1 one cycle after the accepting edge (FIFO previously empty). `hit_cnt` updates at the same edge.
- `snap`/`snap_vd` are registered outputs and hold stable while `snap_vd & ~snap_rdy`.
- Throughput: one push and one pop per cycle.

## Configuration
- `SCR1_TB_INSTR_MON_DISPLAY_EN` defined: every accepted push prints one `$display` line: channel, pc, mstatus, mcycle (hex). Each drop prints `$display` with the current `drop_cnt`+1.
- Undefined: the monitor is silent. The ports and cycle behaviour are identical.

## Structure
- Package `scr1_tb_instr_mon_pkg` holds:
  - the entry struct `type_scr1_tb_instr_snap_s` {ch, pc, mstatus, mcycle}, with the channel field sized by a package constant `SCR1_TB_INSTR_MON_CH_W_MAX` = 4;
  - the mask/value localparams for common opcodes (XOR: mask `0xFE00707F`, value `0x00004033`).
- Sub-module `scr1_tb_instr_snap_fifo` holds the pointers, count, full/empty and simultaneous push/pop logic, parametrised by `DEPTH`.

## Test plan
- Ch0 = XOR mask/value, enabled.
  - Stimulus: accept `instr`=`0x00C5C533`, `pc`=`0x200`, mstatus=`0x1800`, mcycle=`0x55`.
  - Required: next cycle `snap_vd`=1 and `snap`={0, `0x200`, `0x1800`, `0x55`}; `hit_cnt[0]`=1.
- Same instruction with `instr_vd`=1, `instr_rdy`=0 for 3 cycles, then accepted.
  - Required: exactly one entry; `hit_cnt[0]`=1.
- Ch1 = opcode-only mask `0x7F`, value `0x33`, plus ch0 = XOR; accept `0x00C5C533`.
  - Required: `hit_cnt[0]`=1 and `hit_cnt[1]`=1; one entry with ch=0.
- `DEPTH`=8, `snap_rdy`=0; accept 10 matching instructions.
  - Required: 8 entries held, `drop_cnt`=2, `ovf`=1.
  - Then drain: entries come out in PC order.
- FIFO full; in one cycle, pop with `snap_rdy`=1 and accept a hit.
  - Required: the push is accepted, `drop_cnt` is unchanged and the count stays 8.
- Assert `rst_n`=0 for 1 cycle with 3 entries queued and `ovf`=1.
  - Required: next cycle `snap_vd`=0, `ovf`=0, all counters 0.
